// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// edge_event_arbiter: per-channel rising/falling edge capture with one pending
// slot per channel, serialised round-robin onto a valid/ready event port.
// Revision: 1.0
// ============================================================================
module edge_event_arbiter #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  d,
  input  logic [N-1:0]  cfg_rise_en,
  input  logic [N-1:0]  cfg_fall_en,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [CW-1:0] evt_ch,
  output logic          evt_rise,
  output logic [N-1:0]  ovf,
  input  logic [N-1:0]  ovf_clr
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  prev_q, prev_d;
  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  ptype_q, ptype_d;
  logic [N-1:0]  ovf_q, ovf_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic          evt_valid_q, evt_valid_d;
  logic [CW-1:0] evt_ch_q, evt_ch_d;
  logic          evt_rise_q, evt_rise_d;

  logic [N-1:0]  rise_w, fall_w;
  logic          found_w, do_grant_w;
  logic [CW-1:0] gnt_w;
  logic [CW:0]   idx_w;

  assign rise_w = d & ~prev_q & cfg_rise_en;
  assign fall_w = ~d & prev_q & cfg_fall_en;

  // Round-robin search: first pending channel at or above ptr, wrapping.
  always_comb begin
    found_w = 1'b0;
    gnt_w   = '0;
    idx_w   = '0;
    for (int k = 0; k < N; k++) begin
      idx_w = {1'b0, ptr_q} + (CW+1)'(k);
      if (idx_w >= (CW+1)'(N)) idx_w = idx_w - (CW+1)'(N);
      if (!found_w && pend_q[idx_w[CW-1:0]]) begin
        found_w = 1'b1;
        gnt_w   = idx_w[CW-1:0];
      end
    end
  end

  assign do_grant_w = found_w && ((state_q == IDLE) || evt_ready);

  always_comb begin
    state_d     = state_q;
    prev_d      = d;
    pend_d      = pend_q;
    ptype_d     = ptype_q;
    ovf_d       = ovf_q & ~ovf_clr;
    ptr_d       = ptr_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_rise_d  = evt_rise_q;

    // A slot being granted this cycle is free to take a new edge.
    for (int i = 0; i < N; i++) begin
      if (do_grant_w && (gnt_w == CW'(i))) pend_d[i] = 1'b0;
      if (rise_w[i] || fall_w[i]) begin
        if (!pend_d[i]) begin
          pend_d[i]  = 1'b1;
          ptype_d[i] = rise_w[i];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end

    if (do_grant_w) begin
      state_d     = HOLD;
      evt_valid_d = 1'b1;
      evt_ch_d    = gnt_w;
      evt_rise_d  = ptype_q[gnt_w];
      ptr_d       = ({1'b0, gnt_w} + 1'b1 == (CW+1)'(N)) ? '0 : gnt_w + 1'b1;
    end else if ((state_q == HOLD) && evt_ready) begin
      state_d     = IDLE;
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= d;
      pend_q      <= '0;
      ptype_q     <= '0;
      ovf_q       <= '0;
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      pend_q      <= pend_d;
      ptype_q     <= ptype_d;
      ovf_q       <= ovf_d;
      ptr_q       <= ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_rise_q  <= evt_rise_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_rise  = evt_rise_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// tb_edge_event_arbiter: directed stimulus with a scoreboard queue checked by
// an independent handshake monitor.
// Revision: 1.0
// ============================================================================
module tb_edge_event_arbiter;
  localparam int N  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  d;
  logic [N-1:0]  cfg_rise_en;
  logic [N-1:0]  cfg_fall_en;
  logic          evt_valid;
  logic          evt_ready;
  logic [CW-1:0] evt_ch;
  logic          evt_rise;
  logic [N-1:0]  ovf;
  logic [N-1:0]  ovf_clr;

  int checks   = 0;
  int failures = 0;
  logic [CW:0] sb[$];

  edge_event_arbiter #(.N(N), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .d          (d),
    .cfg_rise_en(cfg_rise_en),
    .cfg_fall_en(cfg_fall_en),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ch     (evt_ch),
    .evt_rise   (evt_rise),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input logic r);
    sb.push_back({CW'(ch), r});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      logic [CW:0] e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual=ch%0d/rise%0d expected=none", evt_ch, evt_rise);
      end else begin
        e = sb.pop_front();
        if ({evt_ch, evt_rise} !== e) begin
          failures++;
          $display("FAIL event_order actual=ch%0d/rise%0d expected=ch%0d/rise%0d",
                   evt_ch, evt_rise, e[CW:1], e[0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; d = 4'b0010; cfg_rise_en = 4'b1111; cfg_fall_en = 4'b1111;
    evt_ready = 1'b1; ovf_clr = '0;
    repeat (3) step();
    chk("reset_valid", 32'(evt_valid), 0);
    chk("reset_ch",    32'(evt_ch),    0);
    chk("reset_rise",  32'(evt_rise),  0);
    chk("reset_ovf",   32'(ovf),       0);
    rst = 1'b0;
    repeat (5) step();
    chk("no_edge_after_reset_ovf", 32'(ovf), 0);
    chk("no_edge_after_reset_valid", 32'(evt_valid), 0);

    // Single rising pulse on channel 1, falls disabled.
    cfg_fall_en = '0; step();
    d = '0; repeat (2) step();
    cfg_rise_en = 4'b0010;
    d = 4'b0010; push(1, 1'b1);
    step(); chk("latency_t0_valid", 32'(evt_valid), 0);
    step(); chk("latency_t1_valid", 32'(evt_valid), 1);
    chk("latency_t1_ch", 32'(evt_ch), 1);
    chk("latency_t1_rise", 32'(evt_rise), 1);
    step(); chk("pulse_one_cycle", 32'(evt_valid), 0);
    d = '0; repeat (4) step();

    // All four rise together after a fresh reset: back-to-back 0,1,2,3.
    rst = 1'b1; d = '0; cfg_rise_en = 4'b1111; repeat (2) step();
    rst = 1'b0;
    d = 4'b1111; for (int k = 0; k < N; k++) push(k, 1'b1);
    step();
    for (int k = 0; k < N; k++) begin
      step();
      chk("b2b_valid", 32'(evt_valid), 1);
      chk("b2b_ch", 32'(evt_ch), 32'(k));
    end
    step(); chk("b2b_end_valid", 32'(evt_valid), 0);
    d = '0; repeat (2) step();
    d = 4'b1001; push(0, 1'b1); push(3, 1'b1); repeat (4) step();
    // ptr now 0; grant ch2 moves it to 3, then 3 precedes 0.
    d = 4'b0100; push(2, 1'b1); repeat (3) step();
    d = 4'b1001; push(3, 1'b1); push(0, 1'b1); repeat (4) step();

    // Overflow on ch2 while the port is stalled.
    cfg_fall_en = 4'b1111; evt_ready = 1'b0;
    d = 4'b1011; push(1, 1'b1); repeat (2) step();
    d = 4'b1111; push(2, 1'b1); step();
    d = 4'b1011; step();
    step(); chk("ovf_set", 32'(ovf), 32'h4);
    evt_ready = 1'b1; repeat (3) step();
    ovf_clr = 4'b0100; step(); ovf_clr = '0;
    chk("ovf_clear", 32'(ovf), 0);
    evt_ready = 1'b0;
    d = 4'b1111; push(2, 1'b1); repeat (2) step();
    d = 4'b1011; push(2, 1'b0); step();
    d = 4'b1111; ovf_clr = 4'b0100; step(); ovf_clr = '0;
    chk("ovf_set_beats_clear", 32'(ovf), 32'h4);
    evt_ready = 1'b1; repeat (3) step();
    ovf_clr = 4'b0100; step(); ovf_clr = '0;
    chk("ovf_clear2", 32'(ovf), 0);

    // Reset while an event is presented: it is discarded and ptr returns to 0.
    evt_ready = 1'b0;
    d = 4'b1101; repeat (2) step();
    chk("pre_reset_valid", 32'(evt_valid), 1);
    rst = 1'b1; d = '0; step();
    chk("mid_reset_valid", 32'(evt_valid), 0);
    step(); rst = 1'b0; evt_ready = 1'b1; repeat (3) step();
    d = 4'b1001; push(0, 1'b1); push(3, 1'b1); repeat (4) step();

    // New ch0 edge in the same cycle ch0 is granted.
    cfg_rise_en = '0; cfg_fall_en = '0; d = '0; repeat (2) step();
    cfg_rise_en = 4'b1111; cfg_fall_en = 4'b1111; evt_ready = 1'b0;
    d = 4'b0010; push(1, 1'b1); repeat (2) step();
    d = 4'b0011; push(0, 1'b1); step();
    evt_ready = 1'b1; d = 4'b0010; push(0, 1'b0); step();
    repeat (3) step();
    chk("grant_edge_no_ovf", 32'(ovf), 0);

    repeat (2) step();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
